// File: rtl/pc_branch_sequencer.sv
// pc_branch_sequencer: owns the fetch PC and sequences branches for a 5-stage LEGv8 pipeline
// Ports: clk, reset (sync, active-high); stall from the hazard unit; br_valid/br_type/br_pc/
//   brAddr26/condAddr19/br_reg describe the branch in decode; flags_valid/cbz_zero/cond_true
//   carry the EX outcome; pc is the fetch PC; br_accept, br_taken, flush, busy report status.
// Optional macro PC_BRANCH_STATS_EN adds stats_clear, taken_count and nottaken_count.
module pc_branch_sequencer #(
    parameter int                  PC_WIDTH     = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter int                  FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                br_valid,
    input  logic [1:0]          br_type,
    input  logic [PC_WIDTH-1:0] br_pc,
    input  logic [25:0]         brAddr26,
    input  logic [18:0]         condAddr19,
    input  logic [PC_WIDTH-1:0] br_reg,
    input  logic                flags_valid,
    input  logic                cbz_zero,
    input  logic                cond_true,
`ifdef PC_BRANCH_STATS_EN
    input  logic                stats_clear,
    output logic [31:0]         taken_count,
    output logic [31:0]         nottaken_count,
`endif
    output logic [PC_WIDTH-1:0] pc,
    output logic                br_accept,
    output logic                br_taken,
    output logic                flush,
    output logic                busy
);
    typedef enum logic [1:0] {S_RUN, S_WAIT, S_FLUSH} state_t;

    localparam logic [1:0]          CNT_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [PC_WIDTH-1:0] STEP     = PC_WIDTH'(4);

    state_t              state, state_n;
    logic [PC_WIDTH-1:0] tgt, tgt_n, pc_n, target;
    logic                is_bcond, is_bcond_n, taken_n, flush_n, outcome;
    logic [1:0]          cnt, cnt_n;

    // immediates are word offsets: sign-extend then scale by 4
    assign target = &br_type ? br_reg
                  : br_pc + (br_type == 2'b00 ? {{(PC_WIDTH-28){brAddr26[25]}}, brAddr26, 2'b00}
                                              : {{(PC_WIDTH-21){condAddr19[18]}}, condAddr19, 2'b00});
    assign outcome   = is_bcond ? cond_true : cbz_zero;
    assign br_accept = (state == S_RUN) & br_valid & ~stall;
    assign busy      = state != S_RUN;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        tgt_n      = tgt;
        is_bcond_n = is_bcond;
        cnt_n      = cnt;
        flush_n    = flush;
        taken_n    = 1'b0;
        case (state)
            S_RUN: begin
                if (br_accept) begin
                    // B (00) and BR (11) redirect now; CBZ/B.cond freeze fetch until EX resolves
                    if (br_type[1] == br_type[0]) begin
                        pc_n    = target;
                        taken_n = 1'b1;
                        flush_n = 1'b1;
                        cnt_n   = CNT_INIT;
                        state_n = S_FLUSH;
                    end else begin
                        tgt_n      = target;
                        is_bcond_n = br_type[1];
                        state_n    = S_WAIT;
                    end
                end else if (!stall) begin
                    pc_n = pc + STEP;
                end
            end
            S_WAIT: begin
                if (flags_valid && outcome) begin
                    pc_n    = tgt;
                    taken_n = 1'b1;
                    flush_n = 1'b1;
                    cnt_n   = CNT_INIT;
                    state_n = S_FLUSH;
                end else if (flags_valid) begin
                    pc_n    = pc + STEP;
                    state_n = S_RUN;
                end
            end
            S_FLUSH: begin
                pc_n  = stall ? pc : pc + STEP;
                cnt_n = cnt - 2'd1;
                if (cnt == 2'd0) begin
                    flush_n = 1'b0;
                    state_n = S_RUN;
                end
            end
            default: state_n = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RUN;
            pc       <= RESET_PC;
            tgt      <= '0;
            is_bcond <= 1'b0;
            cnt      <= '0;
            flush    <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            tgt      <= tgt_n;
            is_bcond <= is_bcond_n;
            cnt      <= cnt_n;
            flush    <= flush_n;
            br_taken <= taken_n;
        end
    end

`ifdef PC_BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || stats_clear) begin
            taken_count    <= '0;
            nottaken_count <= '0;
        end else begin
            if (taken_n && !(&taken_count))
                taken_count <= taken_count + 32'd1;
            if (state == S_WAIT && flags_valid && !outcome && !(&nottaken_count))
                nottaken_count <= nottaken_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pc_branch_sequencer.sv
// tb_pc_branch_sequencer: directed and randomized checks of pc_branch_sequencer against a behavioural model
module tb_pc_branch_sequencer;
    localparam logic [63:0] RPC = 64'h100;
    localparam int          FC  = 1;

    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, br_valid = 1'b0;
    logic        flags_valid = 1'b0, cbz_zero = 1'b0, cond_true = 1'b0;
    logic [1:0]  br_type = 2'b00;
    logic [63:0] br_pc = '0, br_reg = '0;
    logic [25:0] brAddr26 = '0;
    logic [18:0] condAddr19 = '0;
    logic [63:0] pc;
    logic        br_accept, br_taken, flush, busy;
`ifdef PC_BRANCH_STATS_EN
    logic        stats_clear = 1'b0;
    logic [31:0] taken_count, nottaken_count;
    logic [31:0] m_tc = '0, m_nc = '0;
`endif

    int          checks = 0, errors = 0;
    logic [63:0] m_pc = RPC, m_pend = '0;
    bit          m_waiting = 1'b0, m_pend_bcond = 1'b0, m_taken = 1'b0, acc_seen = 1'b0;
    int          m_flush_left = 0;

    always #5 clk = ~clk;

    pc_branch_sequencer #(.PC_WIDTH(64), .RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_type(br_type),
        .br_pc(br_pc), .brAddr26(brAddr26), .condAddr19(condAddr19), .br_reg(br_reg),
        .flags_valid(flags_valid), .cbz_zero(cbz_zero), .cond_true(cond_true),
`ifdef PC_BRANCH_STATS_EN
        .stats_clear(stats_clear), .taken_count(taken_count), .nottaken_count(nottaken_count),
`endif
        .pc(pc), .br_accept(br_accept), .br_taken(br_taken), .flush(flush), .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model_target();
        longint off;
        if (br_type == 2'd3) return br_reg;
        if (br_type == 2'd0) begin
            off = longint'(brAddr26);
            if (brAddr26[25]) off -= longint'(1) << 26;
        end else begin
            off = longint'(condAddr19);
            if (condAddr19[18]) off -= longint'(1) << 19;
        end
        return br_pc + 64'(off * 4);
    endfunction

    task automatic model_step();
        bit redirect = 1'b0, not_taken = 1'b0;
        m_taken = 1'b0;
        if (reset) begin
            m_pc = RPC;
            m_waiting = 1'b0;
            m_flush_left = 0;
            m_pend = '0;
        end else if (m_waiting) begin
            if (flags_valid) begin
                m_waiting = 1'b0;
                if (m_pend_bcond ? cond_true : cbz_zero) begin
                    m_pc = m_pend;
                    redirect = 1'b1;
                end else begin
                    m_pc += 4;
                    not_taken = 1'b1;
                end
            end
        end else if (m_flush_left > 0) begin
            if (!stall) m_pc += 4;
            m_flush_left--;
        end else if (!stall) begin
            if (br_valid && (br_type == 2'd0 || br_type == 2'd3)) begin
                m_pc = model_target();
                redirect = 1'b1;
            end else if (br_valid) begin
                m_pend = model_target();
                m_pend_bcond = br_type == 2'd2;
                m_waiting = 1'b1;
            end else begin
                m_pc += 4;
            end
        end
        if (redirect) begin
            m_taken = 1'b1;
            m_flush_left = FC;
        end
`ifdef PC_BRANCH_STATS_EN
        if (reset || stats_clear) begin
            m_tc = '0;
            m_nc = '0;
        end else begin
            if (redirect && m_tc != 32'hFFFF_FFFF) m_tc++;
            if (not_taken && m_nc != 32'hFFFF_FFFF) m_nc++;
        end
`endif
    endtask

    task automatic check_model();
        chk("pc", pc, m_pc);
        chk("br_taken", br_taken, m_taken);
        chk("flush", flush, m_flush_left > 0);
        chk("busy", busy, m_waiting || m_flush_left > 0);
`ifdef PC_BRANCH_STATS_EN
        chk("taken_count", taken_count, m_tc);
        chk("nottaken_count", nottaken_count, m_nc);
`endif
    endtask

    task automatic tick();
        #1;
        acc_seen = br_accept;
        chk("br_accept", br_accept, !m_waiting && m_flush_left == 0 && br_valid && !stall);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("reset_pc", pc, 64'h100);
        chk("reset_flush", flush, 1'b0);
        chk("reset_busy", busy, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("idle_pc", pc, 64'h100 + 64'(4 * i));
        end

        br_valid = 1'b1; br_type = 2'd0; br_pc = 64'h100; brAddr26 = 26'h3FFFFFC;
        tick();
        br_valid = 1'b0;
        chk("b_pc", pc, 64'hF0);
        chk("b_taken", br_taken, 1'b1);
        chk("b_flush", flush, 1'b1);
        tick();
        chk("b_pc_next", pc, 64'hF4);
        chk("b_taken_pulse", br_taken, 1'b0);
        chk("b_flush_off", flush, 1'b0);
        chk("b_run", busy, 1'b0);

        do_reset();
        br_valid = 1'b1; br_type = 2'd1; br_pc = 64'h100; condAddr19 = 19'h00010;
        tick();
        br_valid = 1'b0;
        chk("cbz_hold", pc, 64'h100);
        chk("cbz_busy", busy, 1'b1);
        tick();
        tick();
        chk("cbz_wait_pc", pc, 64'h100);
        flags_valid = 1'b1; cbz_zero = 1'b1;
        tick();
        flags_valid = 1'b0;
        chk("cbz_t_pc", pc, 64'h140);
        chk("cbz_t_flush", flush, 1'b1);
        chk("cbz_t_taken", br_taken, 1'b1);
        tick();

        do_reset();
        br_valid = 1'b1; br_type = 2'd1;
        tick();
        br_valid = 1'b0; flags_valid = 1'b1; cbz_zero = 1'b0;
        tick();
        flags_valid = 1'b0;
        chk("cbz_nt_pc", pc, 64'h104);
        chk("cbz_nt_flush", flush, 1'b0);
        chk("cbz_nt_taken", br_taken, 1'b0);
        chk("cbz_nt_busy", busy, 1'b0);

        do_reset();
        br_valid = 1'b1; br_type = 2'd3; br_reg = 64'hDEAD_BEE0; stall = 1'b1;
        tick();
        chk("br_stall_acc", acc_seen, 1'b0);
        chk("br_stall_pc", pc, 64'h100);
        tick();
        chk("br_stall_pc2", pc, 64'h100);
        stall = 1'b0;
        tick();
        br_valid = 1'b0;
        chk("br_acc", acc_seen, 1'b1);
        chk("br_pc", pc, 64'hDEAD_BEE0);
        tick();

        do_reset();
        br_valid = 1'b1; br_type = 2'd2; br_pc = 64'h100; condAddr19 = 19'h00010;
        tick();
        br_valid = 1'b0;
        chk("wait_busy", busy, 1'b1);
        reset = 1'b1; flags_valid = 1'b1; cond_true = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_wait_pc", pc, 64'h100);
        chk("rst_wait_flush", flush, 1'b0);
        chk("rst_wait_taken", br_taken, 1'b0);
        chk("rst_wait_busy", busy, 1'b0);
        tick();
        flags_valid = 1'b0;
        chk("rst_flags_ignored", pc, 64'h104);

`ifdef PC_BRANCH_STATS_EN
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        repeat (3) begin
            br_valid = 1'b1; br_type = 2'd0;
            tick();
            br_valid = 1'b0;
            tick();
        end
        repeat (2) begin
            br_valid = 1'b1; br_type = 2'd1;
            tick();
            br_valid = 1'b0; flags_valid = 1'b1; cbz_zero = 1'b0;
            tick();
            flags_valid = 1'b0;
        end
        chk("stats_taken", taken_count, 32'd3);
        chk("stats_nottaken", nottaken_count, 32'd2);
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        chk("stats_clr_taken", taken_count, 32'd0);
        chk("stats_clr_nottaken", nottaken_count, 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            reset       = $urandom_range(0, 99) == 0;
            stall       = $urandom_range(0, 3) == 0;
            br_valid    = $urandom_range(0, 2) == 0;
            br_type     = 2'($urandom);
            br_pc       = {$urandom, $urandom};
            br_reg      = {$urandom, $urandom};
            brAddr26    = 26'($urandom);
            condAddr19  = 19'($urandom);
            flags_valid = $urandom_range(0, 2) == 0;
            cbz_zero    = 1'($urandom);
            cond_true   = 1'($urandom);
`ifdef PC_BRANCH_STATS_EN
            stats_clear = $urandom_range(0, 199) == 0;
`endif
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
